// File: rtl/pipes.sv
// Shared decode types: opcodes, funct codes, op/ALU enums and the control_t
// word produced by instr_decode and carried through the decode queue.
package pipes;

   localparam logic [6:0] opcode_I     = 7'b0010011;
   localparam logic [6:0] opcode_R     = 7'b0110011;
   localparam logic [6:0] opcode_I_IW  = 7'b0011011;
   localparam logic [6:0] opcode_R_W   = 7'b0111011;
   localparam logic [6:0] opcode_LUI   = 7'b0110111;
   localparam logic [6:0] opcode_AUIPC = 7'b0010111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SRL  = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // UNKNOWN / ALU_UNKNOWN sit at zero so a cleared entry decodes as illegal.
   typedef enum logic [4:0] {
      UNKNOWN, ADD, SUB, XOR, OR, AND, ADDI, XORI, ORI, ANDI,
      ADDW, SUBW, ADDIW, SLL, SRL, SRA, SLT, SLTU, SLLI, SRLI,
      SRAI, SLTI, SLTIU, LUI, AUIPC, SLLW, SRLW, SRAW, SLLIW, SRLIW, SRAIW
   } op_t;

   typedef enum logic [4:0] {
      ALU_UNKNOWN, ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
      ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW, ALU_LUI, ALU_AUIPC
   } alufunc_t;

   typedef enum logic {FromReg, FromImm} alusrc_t;

   typedef enum logic [1:0] {NoGen, GenI, GenU} imm_gen_t;

   typedef struct packed {
      op_t         op;
      alufunc_t    alufunc;
      alusrc_t     alusrc;
      logic        regwrite;
      imm_gen_t    immGenType;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } control_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational RV64I ALU-subset decoder: 32-bit instruction in, control_t and
// illegal flag out. No state, zero latency, no flow control.
module instr_decode
   import pipes::*;
(
   input  logic [31:0] instr_i,
   output control_t    ctl_o,
   output logic        illegal_o
);

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       alt;
   logic       f7_ok;
   logic       legal;

   assign opcode = instr_i[6:0];
   assign f3     = instr_i[14:12];
   assign f7     = instr_i[31:25];
   assign alt    = instr_i[30];
   // The alternate funct7 is only meaningful in the ADD/SUB and SRL/SRA slots.
   assign f7_ok  = (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SRL)));

   always_comb begin
      ctl_o            = '0;
      legal            = 1'b1;
      ctl_o.regwrite   = 1'b1;
      ctl_o.alusrc     = FromReg;
      ctl_o.immGenType = NoGen;
      ctl_o.rd         = instr_i[11:7];
      ctl_o.rs1        = instr_i[19:15];
      ctl_o.rs2        = instr_i[24:20];
      ctl_o.imm        = '0;
      case (opcode)
         opcode_I: begin
            ctl_o.alusrc     = FromImm;
            ctl_o.immGenType = GenI;
            ctl_o.imm        = {{20{instr_i[31]}}, instr_i[31:20]};
            case (f3)
               F3_ADD:  begin ctl_o.op = ADDI;  ctl_o.alufunc = ALU_ADD;  end
               F3_XOR:  begin ctl_o.op = XORI;  ctl_o.alufunc = ALU_XOR;  end
               F3_OR:   begin ctl_o.op = ORI;   ctl_o.alufunc = ALU_OR;   end
               F3_AND:  begin ctl_o.op = ANDI;  ctl_o.alufunc = ALU_AND;  end
               F3_SLT:  begin ctl_o.op = SLTI;  ctl_o.alufunc = ALU_SLT;  end
               F3_SLTU: begin ctl_o.op = SLTIU; ctl_o.alufunc = ALU_SLTU; end
               F3_SLL: begin
                  ctl_o.op      = SLLI;
                  ctl_o.alufunc = ALU_SLL;
                  legal         = (instr_i[31:26] == 6'b0);
               end
               default: begin
                  ctl_o.op      = alt ? SRAI : SRLI;
                  ctl_o.alufunc = alt ? ALU_SRA : ALU_SRL;
                  legal         = ({instr_i[31], instr_i[29:26]} == 5'b0);
               end
            endcase
         end
         opcode_R: begin
            legal = f7_ok;
            case (f3)
               F3_ADD:  begin ctl_o.op = alt ? SUB : ADD; ctl_o.alufunc = alt ? ALU_SUB : ALU_ADD; end
               F3_XOR:  begin ctl_o.op = XOR;  ctl_o.alufunc = ALU_XOR;  end
               F3_OR:   begin ctl_o.op = OR;   ctl_o.alufunc = ALU_OR;   end
               F3_AND:  begin ctl_o.op = AND;  ctl_o.alufunc = ALU_AND;  end
               F3_SLL:  begin ctl_o.op = SLL;  ctl_o.alufunc = ALU_SLL;  end
               F3_SLT:  begin ctl_o.op = SLT;  ctl_o.alufunc = ALU_SLT;  end
               F3_SLTU: begin ctl_o.op = SLTU; ctl_o.alufunc = ALU_SLTU; end
               default: begin ctl_o.op = alt ? SRA : SRL; ctl_o.alufunc = alt ? ALU_SRA : ALU_SRL; end
            endcase
         end
         opcode_I_IW: begin
            ctl_o.alusrc     = FromImm;
            ctl_o.immGenType = GenI;
            ctl_o.imm        = {{20{instr_i[31]}}, instr_i[31:20]};
            case (f3)
               F3_ADD: begin ctl_o.op = ADDIW; ctl_o.alufunc = ALU_ADDW; end
               F3_SLL: begin
                  ctl_o.op      = SLLIW;
                  ctl_o.alufunc = ALU_SLLW;
                  legal         = (f7 == F7_BASE);
               end
               F3_SRL: begin
                  ctl_o.op      = alt ? SRAIW : SRLIW;
                  ctl_o.alufunc = alt ? ALU_SRAW : ALU_SRLW;
                  legal         = f7_ok;
               end
               default: legal = 1'b0;
            endcase
         end
         opcode_R_W: begin
            legal = f7_ok;
            case (f3)
               F3_ADD:  begin ctl_o.op = alt ? SUBW : ADDW; ctl_o.alufunc = alt ? ALU_SUBW : ALU_ADDW; end
               F3_SLL:  begin ctl_o.op = SLLW; ctl_o.alufunc = ALU_SLLW; end
               F3_SRL:  begin ctl_o.op = alt ? SRAW : SRLW; ctl_o.alufunc = alt ? ALU_SRAW : ALU_SRLW; end
               default: legal = 1'b0;
            endcase
         end
         opcode_LUI, opcode_AUIPC: begin
            ctl_o.op         = (opcode == opcode_LUI) ? LUI : AUIPC;
            ctl_o.alufunc    = (opcode == opcode_LUI) ? ALU_LUI : ALU_AUIPC;
            ctl_o.alusrc     = FromImm;
            ctl_o.immGenType = GenU;
            ctl_o.imm        = {instr_i[31:12], 12'b0};
         end
         default: legal = 1'b0;
      endcase
      // Illegal words still flow to execute, but with an all-zero control word.
      if (!legal) begin
         ctl_o = '0;
      end
      illegal_o = !legal;
   end

endmodule

// File: rtl/decode_queue.sv
// Decode-on-enqueue FIFO between fetch and execute; 1-cycle push-to-valid, no bypass.
// in_ready depends only on registered count and flush; flush wins over push/pop.
module decode_queue
   import pipes::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [XLEN-1:0]            in_pc,
   input  logic [31:0]                in_instr,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XLEN-1:0]            out_pc,
   output logic [31:0]                out_instr,
   output control_t                   out_ctl,
   output logic                       out_illegal,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [XLEN-1:0] pc_q    [DEPTH];
   logic [31:0]     instr_q [DEPTH];
   control_t        ctl_q   [DEPTH];
   logic [DEPTH-1:0] ill_q;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   control_t dec_ctl;
   logic     dec_illegal;
   logic     push, pop;

   instr_decode u_dec (
      .instr_i   (in_instr),
      .ctl_o     (dec_ctl),
      .illegal_o (dec_illegal)
   );

   assign in_ready  = !flush && (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ill_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
            ctl_q[i]   <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push) begin
            pc_q[wr_ptr_q]    <= in_pc;
            instr_q[wr_ptr_q] <= in_instr;
            ctl_q[wr_ptr_q]   <= dec_ctl;
            ill_q[wr_ptr_q]   <= dec_illegal;
         end
      end
   end

   assign out_pc      = pc_q[rd_ptr_q];
   assign out_instr   = instr_q[rd_ptr_q];
   assign out_ctl     = ctl_q[rd_ptr_q];
   assign out_illegal = ill_q[rd_ptr_q];
   assign count       = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode vectors, full/flush/wrap behaviour.
module tb_decode_queue;
   import pipes::*;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic        in_ready, out_valid, out_illegal;
   logic [63:0] in_pc, out_pc;
   logic [31:0] in_instr, out_instr;
   control_t    out_ctl;
   logic [2:0]  count;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   decode_queue #(.DEPTH(4), .XLEN(64)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_pc      (in_pc),
      .in_instr   (in_instr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_pc     (out_pc),
      .out_instr  (out_instr),
      .out_ctl    (out_ctl),
      .out_illegal(out_illegal),
      .count      (count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input logic [63:0] pc, input logic [31:0] ins);
      in_valid = 1'b1;
      in_pc    = pc;
      in_instr = ins;
      step();
      in_valid = 1'b0;
   endtask

   task automatic pop1();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   // Single-entry decode vectors: instruction, expected op, alufunc, illegal.
   typedef struct {
      logic [31:0] ins;
      op_t         op;
      alufunc_t    fn;
      logic        ill;
   } vec_t;

   vec_t vecs [6];

   initial begin
      vecs[0] = '{32'h0020B1B3, SLTU,    ALU_SLTU,    1'b0};
      vecs[1] = '{32'h4020D1BB, SRAW,    ALU_SRAW,    1'b0};
      vecs[2] = '{32'h4020C1B3, UNKNOWN, ALU_UNKNOWN, 1'b1};
      vecs[3] = '{32'h0030919B, SLLIW,   ALU_SLLW,    1'b0};
      vecs[4] = '{32'h00001197, AUIPC,   ALU_AUIPC,   1'b0};
      vecs[5] = '{32'h00000000, UNKNOWN, ALU_UNKNOWN, 1'b1};

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_pc = '0; in_instr = '0;
      step();
      step();
      reset = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_pc", out_pc, 64'd0);
      check("rst_out_instr", 64'(out_instr), 64'd0);
      check("rst_out_ctl", 64'(out_ctl.op) | 64'(out_ctl.alufunc) | 64'(out_ctl.imm), 64'd0);
      check("rst_out_illegal", 64'(out_illegal), 64'd0);

      // addi x1,x0,5
      push1(64'h1000, 32'h00500093);
      check("addi_valid", 64'(out_valid), 64'd1);
      check("addi_op", 64'(out_ctl.op), 64'(ADDI));
      check("addi_fn", 64'(out_ctl.alufunc), 64'(ALU_ADD));
      check("addi_regwrite", 64'(out_ctl.regwrite), 64'd1);
      check("addi_illegal", 64'(out_illegal), 64'd0);
      check("addi_count", 64'(count), 64'd1);
      check("addi_pc", out_pc, 64'h1000);
      check("addi_imm", 64'(out_ctl.imm), 64'd5);
      pop1();
      check("addi_popped", 64'(out_valid), 64'd0);

      push1(64'h1004, 32'h402081B3);
      push1(64'h1008, 32'h4030D093);
      push1(64'h100C, 32'h123452B7);
      check("three_count", 64'(count), 64'd3);
      check("sub_op", 64'(out_ctl.op), 64'(SUB));
      check("sub_fn", 64'(out_ctl.alufunc), 64'(ALU_SUB));
      pop1();
      check("srai_op", 64'(out_ctl.op), 64'(SRAI));
      check("srai_fn", 64'(out_ctl.alufunc), 64'(ALU_SRA));
      pop1();
      check("lui_op", 64'(out_ctl.op), 64'(LUI));
      check("lui_imm_gen", 64'(out_ctl.immGenType), 64'(GenU));
      check("lui_alusrc", 64'(out_ctl.alusrc), 64'(FromImm));
      check("lui_imm", 64'(out_ctl.imm), 64'h12345000);
      check("lui_pc", out_pc, 64'h100C);
      pop1();

      foreach (vecs[i]) begin
         push1(64'h1100 + 64'(i), vecs[i].ins);
         check($sformatf("vec%0d_op", i), 64'(out_ctl.op), 64'(vecs[i].op));
         check($sformatf("vec%0d_fn", i), 64'(out_ctl.alufunc), 64'(vecs[i].fn));
         check($sformatf("vec%0d_ill", i), 64'(out_illegal), 64'(vecs[i].ill));
         check($sformatf("vec%0d_regwrite", i), 64'(out_ctl.regwrite), 64'(!vecs[i].ill));
         check($sformatf("vec%0d_instr", i), 64'(out_instr), 64'(vecs[i].ins));
         pop1();
      end

      // Fill to DEPTH with execute stalled.
      for (int i = 0; i < 4; i++) push1(64'h2000 + 64'(4 * i), 32'h00500093);
      check("full_count", 64'(count), 64'd4);
      check("full_in_ready", 64'(in_ready), 64'd0);
      push1(64'h2FFF, 32'h00500093);
      check("full_reject_count", 64'(count), 64'd4);
      check("full_head", out_pc, 64'h2000);
      in_valid = 1'b1; in_pc = 64'h2EEE; out_ready = 1'b1;
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      check("full_pop_count", 64'(count), 64'd3);
      check("full_pop_head", out_pc, 64'h2004);
      check("full_pop_ready", 64'(in_ready), 64'd1);

      // Flush at count=3 with push and pop both requested.
      flush = 1'b1; in_valid = 1'b1; in_pc = 64'h3FFF; out_ready = 1'b1;
      #1;
      check("flush_in_ready", 64'(in_ready), 64'd0);
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check("flush_count", 64'(count), 64'd0);
      check("flush_valid", 64'(out_valid), 64'd0);
      push1(64'h4000, 32'h00500093);
      check("post_flush_head", out_pc, 64'h4000);
      check("post_flush_count", 64'(count), 64'd1);
      pop1();

      // Steady push+pop at count=2 across pointer wrap.
      push1(64'h5000, 32'h00500093);
      push1(64'h5004, 32'h00500093);
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_pc = 64'h5008 + 64'(4 * i);
         step();
         check($sformatf("wrap%0d_count", i), 64'(count), 64'd2);
         check($sformatf("wrap%0d_head", i), out_pc, 64'h5004 + 64'(4 * i));
      end
      in_valid = 1'b0; out_ready = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
